// File: rtl/fxp_accum_pkg.sv
// ============================================================================
// Module  : fxp_accum_pkg
// Brief   : Shared state encoding and guard-bit helper for fxp_accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fxp_accum_pkg;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} accum_state_t;

  // Extra accumulator MSBs needed so that len full-scale operands cannot overflow.
  function automatic int guard_bits(input int len);
    return (len <= 1) ? 0 : $clog2(len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fxp_saturate.sv
// ============================================================================
// Module  : fxp_saturate
// Brief   : Combinational clamp from an (n+G)-bit sum to n bits, with ovf flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_saturate #(
  parameter int n    = 32,
  parameter int G    = 2,
  parameter int sign = 1
) (
  input  logic [n+G-1:0] din,
  output logic [n-1:0]   dout,
  output logic           ovf
);

  if (G == 0) begin : g_pass
    assign dout = din;
    assign ovf  = 1'b0;
  end else if (sign != 0) begin : g_signed
    // In range only when the G guard bits and the result MSB all agree.
    logic w_pos_ovf;
    logic w_neg_ovf;
    assign w_pos_ovf = ~din[n+G-1] &  (|din[n+G-2:n-1]);
    assign w_neg_ovf =  din[n+G-1] & ~(&din[n+G-2:n-1]);
    assign ovf  = w_pos_ovf | w_neg_ovf;
    assign dout = w_pos_ovf ? {1'b0, {(n-1){1'b1}}} :
                  w_neg_ovf ? {1'b1, {(n-1){1'b0}}} :
                  din[n-1:0];
  end else begin : g_unsigned
    logic w_hi_ovf;
    assign w_hi_ovf = |din[n+G-1:n];
    assign ovf  = w_hi_ovf;
    assign dout = w_hi_ovf ? {n{1'b1}} : din[n-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/fxp_accumulator.sv
// ============================================================================
// Module  : fxp_accumulator
// Brief   : Sums LEN fixed-point products into one result over val/rdy links.
//           Define FXP_ACCUM_SATURATE_EN to clamp the result instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_accumulator
  import fxp_accum_pkg::*;
#(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int sign = 1,
  parameter int LEN  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         snd_val,
  output logic         snd_rdy,
  input  logic [n-1:0] a,
  output logic         rcv_val,
  input  logic         rcv_rdy,
  output logic [n-1:0] c,
  output logic         ovf
);

  localparam int c_GUARD = guard_bits(LEN);
  localparam int c_W     = n + c_GUARD;
  localparam int c_CW    = $clog2(LEN + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(LEN - 1);

  if (LEN < 1 || d < 0 || d > n) begin : g_param_check
    $error("fxp_accumulator: illegal LEN or d parameter");
  end

  accum_state_t    r_state;
  accum_state_t    w_state_next;
  logic            w_accept;
  logic            w_last;
  logic            w_release;

  logic [c_W-1:0]  r_acc;
  logic [c_CW-1:0] r_count;
  logic            r_rcv_val;
  logic [n-1:0]    r_c;
  logic            r_ovf;

  logic [c_W-1:0]  w_ext;
  logic [c_W-1:0]  w_sum;
  logic [n-1:0]    w_res;
  logic            w_res_ovf;

  if (sign != 0) begin : g_sext
    assign w_ext = c_W'($signed(a));
  end else begin : g_zext
    assign w_ext = c_W'(a);
  end

  assign w_sum = r_acc + w_ext;

`ifdef FXP_ACCUM_SATURATE_EN
  fxp_saturate #(
    .n    (n),
    .G    (c_GUARD),
    .sign (sign)
  ) u_saturate (
    .din  (w_sum),
    .dout (w_res),
    .ovf  (w_res_ovf)
  );
`else
  assign w_res     = w_sum[n-1:0];
  assign w_res_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ACCUM: begin
        if (snd_val) begin
          w_accept = 1'b1;
          if (r_count == c_LAST) begin
            w_last       = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        if (rcv_rdy) begin
          w_release    = 1'b1;
          w_state_next = ACCUM;
        end
      end
      default: w_state_next = ACCUM;
    endcase
  end

  // Result registers only load on the final product, so they hold through DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_rcv_val <= 1'b0;
      r_c       <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc   <= w_sum;
        r_count <= w_last ? '0 : r_count + c_CW'(1);
      end
      if (w_last) begin
        r_rcv_val <= 1'b1;
        r_c       <= w_res;
        r_ovf     <= w_res_ovf;
      end
      if (w_release) begin
        r_rcv_val <= 1'b0;
        r_acc     <= '0;
      end
    end
  end

  assign snd_rdy = (r_state == ACCUM);
  assign rcv_val = r_rcv_val;
  assign c       = r_c;
  assign ovf     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fxp_accumulator.sv
// ============================================================================
// Module  : tb_fxp_accumulator
// Brief   : Directed self-checking bench for fxp_accumulator (signed, unsigned
//           and LEN=1 instances); honours FXP_ACCUM_SATURATE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fxp_accumulator;

`ifdef FXP_ACCUM_SATURATE_EN
  localparam logic [31:0] EXP3_C = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP3_O = 32'd1;
  localparam logic [31:0] EXP4_C = 32'h8000_0000;
  localparam logic [31:0] EXP4_O = 32'd1;
  localparam logic [31:0] EXP6_C = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP6_O = 32'd1;
`else
  localparam logic [31:0] EXP3_C = 32'hFFFC_0000;
  localparam logic [31:0] EXP3_O = 32'd0;
  localparam logic [31:0] EXP4_C = 32'h0000_0000;
  localparam logic [31:0] EXP4_O = 32'd0;
  localparam logic [31:0] EXP6_C = 32'hFFFF_FFFC;
  localparam logic [31:0] EXP6_O = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        snd_val, snd_rdy, rcv_val, rcv_rdy, ovf;
  logic [31:0] a, c;
  logic        u_snd_val, u_snd_rdy, u_rcv_val, u_rcv_rdy, u_ovf;
  logic [31:0] u_a, u_c;
  logic        l_snd_val, l_snd_rdy, l_rcv_val, l_rcv_rdy, l_ovf;
  logic [31:0] l_a, l_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fxp_accumulator #(.n(32), .d(16), .sign(1), .LEN(4)) u_dut (
    .clk(clk), .reset(reset), .snd_val(snd_val), .snd_rdy(snd_rdy), .a(a),
    .rcv_val(rcv_val), .rcv_rdy(rcv_rdy), .c(c), .ovf(ovf)
  );

  fxp_accumulator #(.n(32), .d(16), .sign(0), .LEN(4)) u_dut_uns (
    .clk(clk), .reset(reset), .snd_val(u_snd_val), .snd_rdy(u_snd_rdy), .a(u_a),
    .rcv_val(u_rcv_val), .rcv_rdy(u_rcv_rdy), .c(u_c), .ovf(u_ovf)
  );

  fxp_accumulator #(.n(32), .d(16), .sign(1), .LEN(1)) u_dut_len1 (
    .clk(clk), .reset(reset), .snd_val(l_snd_val), .snd_rdy(l_snd_rdy), .a(l_a),
    .rcv_val(l_rcv_val), .rcv_rdy(l_rcv_rdy), .c(l_c), .ovf(l_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product and return just after the edge that accepts it.
  task automatic send(input logic [31:0] v);
    int k;
    k       = 0;
    a       = v;
    snd_val = 1'b1;
    while (!snd_rdy && k < 20) begin
      tick();
      k++;
    end
    if (!snd_rdy) check("send_rdy_timeout", {31'd0, snd_rdy}, 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    snd_val = 1'b0; a = '0; rcv_rdy = 1'b1;
    u_snd_val = 1'b0; u_a = '0; u_rcv_rdy = 1'b1;
    l_snd_val = 1'b0; l_a = '0; l_rcv_rdy = 1'b0;

    #2;
    check("rst_rcv_val", {31'd0, rcv_val}, 32'd0);
    check("rst_c",       c,                32'd0);
    check("rst_ovf",     {31'd0, ovf},     32'd0);
    check("rst_snd_rdy", {31'd0, snd_rdy}, 32'd1);
    #10 reset = 1'b1;
    tick();

    // Mixed-sign back-to-back products, 1 + 2 - 0.5 + 0.25 = 2.75
    send(32'h0001_0000);
    send(32'h0002_0000);
    send(32'hFFFF_8000);
    check("t1_early_val", {31'd0, rcv_val}, 32'd0);
    send(32'h0000_4000);
    snd_val = 1'b0;
    check("t1_rcv_val", {31'd0, rcv_val}, 32'd1);
    check("t1_c",       c,                32'h0002_C000);
    check("t1_ovf",     {31'd0, ovf},     32'd0);
    check("t1_snd_rdy", {31'd0, snd_rdy}, 32'd0);
    tick();
    check("t1_rel_val", {31'd0, rcv_val}, 32'd0);
    check("t1_rel_rdy", {31'd1 & 31'd0, snd_rdy}, 32'd1);

    // Backpressure: result held in DONE while upstream keeps offering data
    rcv_rdy = 1'b0;
    repeat (4) send(32'h0001_0000);
    check("t2_c", c, 32'h0004_0000);
    a = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_val", {31'd0, rcv_val}, 32'd1);
      check("t2_hold_c",   c,                32'h0004_0000);
      check("t2_hold_rdy", {31'd0, snd_rdy}, 32'd0);
    end
    snd_val = 1'b0;
    rcv_rdy = 1'b1;
    tick();
    check("t2_rel_val", {31'd0, rcv_val}, 32'd0);
    check("t2_rel_rdy", {31'd0, snd_rdy}, 32'd1);

    // Positive overflow; also shows acc was cleared after the held result
    repeat (4) send(32'h7FFF_0000);
    snd_val = 1'b0;
    check("t3_c",   c,            EXP3_C);
    check("t3_ovf", {31'd0, ovf}, EXP3_O);

    // Asynchronous reset after two accepts discards the partial sum
    send(32'h0001_0000);
    send(32'h0001_0000);
    snd_val = 1'b0;
    reset   = 1'b0;
    #1;
    check("t5_rst_val", {31'd0, rcv_val}, 32'd0);
    check("t5_rst_c",   c,                32'd0);
    check("t5_rst_rdy", {31'd0, snd_rdy}, 32'd1);
    #1 reset = 1'b1;
    repeat (3) send(32'h0001_0000);
    check("t5_early_val", {31'd0, rcv_val}, 32'd0);
    send(32'h0001_0000);
    snd_val = 1'b0;
    check("t5_val", {31'd0, rcv_val}, 32'd1);
    check("t5_c",   c,                32'h0004_0000);

    // Negative overflow
    repeat (4) send(32'h8000_0000);
    snd_val = 1'b0;
    check("t4_c",   c,            EXP4_C);
    check("t4_ovf", {31'd0, ovf}, EXP4_O);

    // Unsigned instance: 4 x all-ones
    u_a       = 32'hFFFF_FFFF;
    u_snd_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t6_snd_rdy", {31'd0, u_snd_rdy}, 32'd1);
      tick();
    end
    u_snd_val = 1'b0;
    check("t6_val", {31'd0, u_rcv_val}, 32'd1);
    check("t6_c",   u_c,                EXP6_C);
    check("t6_ovf", {31'd0, u_ovf},     EXP6_O);

    // LEN=1 goes straight to DONE on every accept
    l_a       = 32'h0003_0000;
    l_snd_val = 1'b1;
    tick();
    l_snd_val = 1'b0;
    check("l1_val", {31'd0, l_rcv_val}, 32'd1);
    check("l1_c",   l_c,                32'h0003_0000);
    check("l1_rdy", {31'd0, l_snd_rdy}, 32'd0);
    l_rcv_rdy = 1'b1;
    tick();
    check("l1_rel_val", {31'd0, l_rcv_val}, 32'd0);
    check("l1_rel_rdy", {31'd0, l_snd_rdy}, 32'd1);
    l_a       = 32'hFFFF_0000;
    l_snd_val = 1'b1;
    tick();
    l_snd_val = 1'b0;
    check("l1_c2",   l_c,            32'hFFFF_0000);
    check("l1_ovf2", {31'd0, l_ovf}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
